// File: rtl/ehockey_pkg.sv
// Shared types and constants for the E-Hockey front-panel and game control logic.
package ehockey_pkg;

  localparam int MODE_W           = 3;
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    ST_MENU   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_PLAY   = 2'd2
  } state_e;

  // Wrap by explicit compare so mode counts below 8 wrap correctly.
  function automatic logic [MODE_W-1:0] mode_step(
    input logic [MODE_W-1:0] cur,
    input logic              up,
    input logic [MODE_W-1:0] max_mode
  );
    if (up) begin
      mode_step = (cur == max_mode) ? '0 : cur + MODE_W'(1);
    end else begin
      mode_step = (cur == '0) ? max_mode : cur - MODE_W'(1);
    end
  endfunction

endpackage

// File: rtl/menu_mode_select_if.sv
// Button, game-status and menu-output bundle between the front panel and menu control.
interface menu_mode_select_if;
  import ehockey_pkg::*;

  logic              btn_up;
  logic              btn_down;
  logic              btn_sel;
  logic              game_over;
  logic [MODE_W-1:0] mode;
  logic [MODE_W-1:0] game_mode;
  logic              in_menu;
  logic              start;

  modport master (
    output btn_up, btn_down, btn_sel, game_over,
    input  mode, game_mode, in_menu, start
  );

  modport slave (
    input  btn_up, btn_down, btn_sel, game_over,
    output mode, game_mode, in_menu, start
  );

endinterface

// File: rtl/menu_mode_select_button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, registered rising-edge pulse.
// Level follows raw after DEBOUNCE_CYCLES stable samples; press lags level by one cycle.
module button_debounce
  import ehockey_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int             CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             prev_q, press_q;

  // The flip happens on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/menu_mode_select.sv
// Menu cursor and menu/launch/play sequencer driven by three debounced buttons.
// start and the latched game_mode appear one cycle after the select press; in_menu drops one cycle later.
module menu_mode_select
  import ehockey_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int NUM_MODES       = 8
) (
  input  logic               clk,
  input  logic               reset,
  menu_mode_select_if.slave  bus
);

  localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NUM_MODES - 1);

  logic up_press, down_press, sel_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .reset(reset), .raw(bus.btn_up), .level(), .press(up_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .reset(reset), .raw(bus.btn_down), .level(), .press(down_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk(clk), .reset(reset), .raw(bus.btn_sel), .level(), .press(sel_press)
  );

  state_e            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [MODE_W-1:0] game_mode_q, game_mode_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_MENU;
      mode_q      <= '0;
      game_mode_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      game_mode_q <= game_mode_d;
    end
  end

  // game_mode is captured on entry to LAUNCH so it is valid alongside start.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    game_mode_d = game_mode_q;
    case (state_q)
      ST_MENU: begin
        if (sel_press) begin
          state_d     = ST_LAUNCH;
          game_mode_d = mode_q;
        end else if (up_press && !down_press) begin
          mode_d = mode_step(mode_q, 1'b1, MAX_MODE);
        end else if (down_press && !up_press) begin
          mode_d = mode_step(mode_q, 1'b0, MAX_MODE);
        end
      end
      ST_LAUNCH: state_d = ST_PLAY;
      ST_PLAY: begin
        if (bus.game_over) state_d = ST_MENU;
      end
      default: state_d = ST_MENU;
    endcase
  end

  assign bus.mode      = mode_q;
  assign bus.game_mode = game_mode_q;
  assign bus.in_menu   = (state_q != ST_PLAY);
  assign bus.start     = (state_q == ST_LAUNCH);

endmodule

// File: tb/tb_menu_mode_select.sv
// Directed checks of debounce latency, mode wrap, glitch rejection and the menu/launch/play sequence.
module tb_menu_mode_select;
  import ehockey_pkg::*;

  localparam int B_UP = 0, B_DOWN = 1, B_SEL = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  menu_mode_select_if bus ();

  menu_mode_select #(.DEBOUNCE_CYCLES(4), .NUM_MODES(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_UP:    bus.btn_up   = v;
      B_DOWN:  bus.btn_down = v;
      default: bus.btn_sel  = v;
    endcase
  endtask

  // Hold long enough to debounce, then release and let the release settle.
  task automatic tap(input int b);
    set_btn(b, 1'b1);
    repeat (10) tick();
    set_btn(b, 1'b0);
    repeat (10) tick();
  endtask

  initial begin
    int bad;
    int starts;
    int start_cyc;
    int gm_at_start;
    int menu_at_start;
    int menu_after;

    reset         = 1'b1;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_sel   = 1'b0;
    bus.game_over = 1'b0;
    repeat (3) tick();
    check_val("rst_mode", bus.mode, 0);
    check_val("rst_game_mode", bus.game_mode, 0);
    check_val("rst_in_menu", bus.in_menu, 1);
    check_val("rst_start", bus.start, 0);
    reset = 1'b0;
    tick();

    // Up held 10 cycles: mode changes on the 8th edge after the raw rise.
    bad = 0;
    set_btn(B_UP, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.start !== 1'b0 || bus.in_menu !== 1'b1) bad++;
      if (i == 7) check_val("up_before_latency", bus.mode, 0);
      if (i == 8) check_val("up_at_latency", bus.mode, 1);
    end
    set_btn(B_UP, 1'b0);
    repeat (10) tick();
    check_val("up_single_press", bus.mode, 1);
    check_val("menu_flags_steady", bad, 0);

    tap(B_DOWN);
    check_val("down_to_0", bus.mode, 0);
    tap(B_DOWN);
    check_val("down_wrap_7", bus.mode, 7);
    tap(B_UP);
    check_val("up_wrap_0", bus.mode, 0);

    for (int i = 0; i < 40; i++) begin
      set_btn(B_UP, (i % 4) < 2);
      tick();
    end
    set_btn(B_UP, 1'b0);
    repeat (10) tick();
    check_val("glitch_reject", bus.mode, 0);

    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    repeat (10) tick();
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    repeat (10) tick();
    check_val("up_down_same_cycle", bus.mode, 0);

    repeat (5) tap(B_UP);
    check_val("mode_5", bus.mode, 5);

    // Select: press pulse on edge 7, start on edge 8, in_menu low from edge 9.
    starts = 0; start_cyc = -1; gm_at_start = -1; menu_at_start = -1; menu_after = -1;
    set_btn(B_SEL, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == start_cyc + 1) menu_after = bus.in_menu;
      if (bus.start === 1'b1) begin
        starts++;
        start_cyc     = i;
        gm_at_start   = bus.game_mode;
        menu_at_start = bus.in_menu;
      end
    end
    set_btn(B_SEL, 1'b0);
    check_val("start_pulses", starts, 1);
    check_val("start_cycle", start_cyc, 8);
    check_val("game_mode_at_start", gm_at_start, 5);
    check_val("in_menu_at_start", menu_at_start, 1);
    check_val("in_menu_after_start", menu_after, 0);
    repeat (10) tick();

    tap(B_UP);
    tap(B_DOWN);
    check_val("play_mode_hold", bus.mode, 5);
    check_val("play_in_menu", bus.in_menu, 0);
    check_val("play_start_low", bus.start, 0);

    bus.game_over = 1'b1;
    tick();
    bus.game_over = 1'b0;
    check_val("game_over_in_menu", bus.in_menu, 1);
    check_val("game_over_mode", bus.mode, 5);
    check_val("game_over_game_mode", bus.game_mode, 5);

    tap(B_SEL);
    check_val("relaunch_in_play", bus.in_menu, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("mid_rst_in_menu", bus.in_menu, 1);
    check_val("mid_rst_mode", bus.mode, 0);
    check_val("mid_rst_game_mode", bus.game_mode, 0);
    check_val("mid_rst_start", bus.start, 0);

    set_btn(B_SEL, 1'b1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.start === 1'b1) starts++;
    end
    set_btn(B_SEL, 1'b0);
    check_val("held_sel_launches", starts, 1);
    check_val("held_sel_in_play", bus.in_menu, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/menu_mode_select.md
# menu_mode_select

Front-panel control stage for the E-Hockey menu screen. It debounces the up, down and select push-buttons and keeps the current menu mode index (0..7), which the menu renderer draws as the digit after "MODE". It also sequences menu → game → menu, latching the chosen mode for the game logic and telling the VGA mux which screen to draw.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable synchronized samples needed to accept a button level change (10 ms at 100 MHz). Minimum 2.
- NUM_MODES, default 8: number of selectable modes. Legal range 2..8.

Ports:
- clk  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- btn_up  in  1  raw, asynchronous push-button; high = pressed.
- btn_down  in  1  raw, asynchronous push-button; high = pressed.
- btn_sel  in  1  raw, asynchronous push-button; high = pressed.
- game_over  in  1  one-cycle pulse from game logic; returns the block to the menu.
- mode  out  3  menu cursor index; drives the menu renderer's mode input.
- game_mode  out  3  mode latched at launch; stable for the whole game.
- in_menu  out  1  high while the menu screen is shown; VGA mux select.
- start  out  1  one-cycle pulse at launch; resets and arms the game logic.

## Operation
- Each button path: 2-FF synchronizer, then a stability counter, then a rising-edge detector.
  - Counter clears whenever the synchronized sample equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES−1, the debounced level flips and the counter clears.
  - The press pulse is a registered, one-cycle pulse on a debounced 0→1 transition. Releases produce no pulse.
- FSM states:
  - MENU: in_menu=1.
    - up_press alone: mode = (mode==NUM_MODES−1) ? 0 : mode+1.
    - down_press alone: mode = (mode==0) ? NUM_MODES−1 : mode−1.
    - up_press and down_press in the same cycle: mode unchanged.
    - sel_press: go to LAUNCH. Takes priority over up/down in the same cycle; mode is unchanged in that cycle.
  - LAUNCH: lasts one cycle.
    - start=1, game_mode←mode, in_menu=1.
    - Next state is PLAY unconditionally.
  - PLAY: in_menu=0.
    - All press pulses are ignored, and mode holds its value.
    - game_over: go to MENU. mode keeps its last value, so the cursor stays on the last game.
- game_over is ignored in MENU and LAUNCH.
- Debouncers keep running in all states, so a button held through PLAY produces no press on return to MENU.
- Arithmetic: mode is 3-bit unsigned. Wrap uses explicit compares, never natural overflow, so any NUM_MODES < 8 is supported.

## Timing
- Reset values:
  - mode=0, game_mode=0, in_menu=1, start=0, state=MENU.
  - Synchronizers, counters and debounced levels = 0; edge registers = 0.
- Reset asserted mid-operation (including in LAUNCH or PLAY): all of the above apply on the next edge, and no start pulse is emitted.
- A button held across reset release is seen as a new press once DEBOUNCE_CYCLES has elapsed.
- Latency, with raw input high from the sampling edge at cycle t:
  - synchronized value at t+2;
  - debounced level high at t+2+DEBOUNCE_CYCLES;
  - press pulse at t+3+DEBOUNCE_CYCLES;
  - mode updated at t+4+DEBOUNCE_CYCLES.
- Select path:
  - sel press pulse at cycle p → start=1 and game_mode valid at p+1;
  - in_menu falls at p+2.
- game_over at cycle g → in_menu=1 at g+1.
- Glitches shorter than DEBOUNCE_CYCLES samples produce no press.

## Structure
- Shared package ehockey_pkg:
  - state encoding typedef (MENU, LAUNCH, PLAY);
  - MODE_W=3;
  - default DEBOUNCE_CYCLES constant.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES), instantiated three times. Ports: clk, reset, raw, level, press.
- Counter width = $clog2(DEBOUNCE_CYCLES).

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NUM_MODES=8.
- Reset, then hold btn_up for 10 cycles → exactly one press; mode=1 at t+8; in_menu=1, start=0 throughout.
- From mode=0, one btn_down press → mode=7. From mode=7, one btn_up press → mode=0.
- btn_up toggling with 2-cycle high / 2-cycle low glitches for 40 cycles → mode unchanged. Debounced up and down pulses landing in the same cycle → mode unchanged.
- Set mode=5, press btn_sel → start high for exactly 1 cycle, game_mode=5 on that cycle, in_menu=0 the cycle after. Up/down presses during PLAY → mode stays 5. game_over pulse → in_menu=1 next cycle, mode=5.
- Assert reset for one cycle during PLAY → next edge gives in_menu=1, mode=0, game_mode=0, start=0. Hold btn_sel across reset → exactly one LAUNCH after debounce.
